// File: rtl/game_pkg.sv
// Shared definitions for the game-area playfield store: default geometry,
// FSM state encoding and a small saturating-counter helper.
package game_pkg;

  localparam int          DEF_ROWS      = 20;
  localparam int          DEF_COLS      = 12;
  localparam logic [11:0] DEF_FULL_MASK = 12'hFFF;
  localparam int          ADDR_W        = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    FILL = 3'd2,
    WIPE = 3'd3,
    DONE = 3'd4
  } state_t;

  // Increment a 3-bit count, sticking at 7
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    if (v == 3'd7) begin
      return v;
    end else begin
      return v + 3'd1;
    end
  endfunction

endpackage

// File: rtl/game_area_store_if.sv
// Bus between the game logic / renderer side (master) and the playfield
// store (slave): renderer read port, lock merge handshake, clear/wipe control.
interface game_area_store_if #(
  parameter int COLS = game_pkg::DEF_COLS
);
  logic [4:0]      rd_addr;
  logic [COLS-1:0] rd_data;
  logic            lock_valid;
  logic [4:0]      lock_row;
  logic [COLS-1:0] lock_mask;
  logic            lock_ready;
  logic            clear_start;
  logic            board_wipe;
  logic            busy;
  logic            done;
  logic [2:0]      lines_cleared;

  modport master (
    output rd_addr, lock_valid, lock_row, lock_mask, clear_start, board_wipe,
    input  rd_data, lock_ready, busy, done, lines_cleared
  );

  modport slave (
    input  rd_addr, lock_valid, lock_row, lock_mask, clear_start, board_wipe,
    output rd_data, lock_ready, busy, done, lines_cleared
  );
endinterface

// File: rtl/game_area_store_board_regfile.sv
// ROWS x COLS occupancy flop array: one write port, two combinational read
// ports (control FSM and renderer). Out-of-range reads return zero.
module board_regfile #(
  parameter int ROWS = game_pkg::DEF_ROWS,
  parameter int COLS = game_pkg::DEF_COLS
) (
  input  logic            vga_clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [COLS-1:0] wdata,
  input  logic [4:0]      raddr_a,
  output logic [COLS-1:0] rdata_a,
  input  logic [4:0]      raddr_b,
  output logic [COLS-1:0] rdata_b
);
  import game_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  logic [COLS-1:0] mem_r [ROWS];

  // Row storage: cleared on reset, single write per cycle
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        mem_r[i] <= {COLS{1'b0}};
      end
    end else if (we && (waddr <= LAST_ROW)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // FSM-side read port
  always_comb begin
    rdata_a = {COLS{1'b0}};
    if (raddr_a <= LAST_ROW) begin
      rdata_a = mem_r[raddr_a];
    end else begin
      rdata_a = {COLS{1'b0}};
    end
  end

  // Renderer-side read port
  always_comb begin
    rdata_b = {COLS{1'b0}};
    if (raddr_b <= LAST_ROW) begin
      rdata_b = mem_r[raddr_b];
    end else begin
      rdata_b = {COLS{1'b0}};
    end
  end

endmodule

// File: rtl/game_area_store.sv
// Playfield store: renderer read port, row-wise lock merge, line-clear
// collapse (bottom-up copy then top fill) and full-board wipe.
module game_area_store #(
  parameter int              ROWS      = game_pkg::DEF_ROWS,
  parameter int              COLS      = game_pkg::DEF_COLS,
  parameter logic [COLS-1:0] FULL_MASK = game_pkg::DEF_FULL_MASK
) (
  input logic              vga_clk,
  input logic              rst,
  game_area_store_if.slave bus
);
  import game_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  state_t            state_r, next_state_s;
  logic [ADDR_W-1:0] rp_r, wp_r;
  logic [2:0]        count_r, count_next_s, lines_r;
  logic [COLS-1:0]   rd_data_r;
  logic              we_s, lock_ready_s, busy_s, done_s, row_full_s;
  logic [ADDR_W-1:0] waddr_s, fsm_raddr_s;
  logic [COLS-1:0]   wdata_s, fsm_rdata_s, ren_rdata_s;

  board_regfile #(.ROWS(ROWS), .COLS(COLS)) u_regfile (
    .vga_clk (vga_clk),
    .rst     (rst),
    .we      (we_s),
    .waddr   (waddr_s),
    .wdata   (wdata_s),
    .raddr_a (fsm_raddr_s),
    .rdata_a (fsm_rdata_s),
    .raddr_b (bus.rd_addr),
    .rdata_b (ren_rdata_s)
  );

  assign row_full_s        = ((fsm_rdata_s & FULL_MASK) == FULL_MASK);
  assign bus.rd_data       = rd_data_r;
  assign bus.lock_ready    = lock_ready_s;
  assign bus.busy          = busy_s;
  assign bus.done          = done_s;
  assign bus.lines_cleared = lines_r;

  // Full-row count including the row under the read pointer this cycle
  always_comb begin
    count_next_s = count_r;
    if ((state_r == SCAN) && row_full_s) begin
      count_next_s = sat_inc3(count_r);
    end else begin
      count_next_s = count_r;
    end
  end

  // State register
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: wipe beats clear in IDLE; scan/fill/wipe walk pointers to row 0
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.board_wipe) begin
          next_state_s = WIPE;
        end else if (bus.clear_start) begin
          next_state_s = SCAN;
        end else begin
          next_state_s = IDLE;
        end
      end
      SCAN: begin
        if (rp_r == {ADDR_W{1'b0}}) begin
          next_state_s = (count_next_s != 3'd0) ? FILL : DONE;
        end else begin
          next_state_s = SCAN;
        end
      end
      FILL, WIPE: begin
        if (wp_r == {ADDR_W{1'b0}}) begin
          next_state_s = DONE;
        end else begin
          next_state_s = state_r;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output/write-port decode for the current state
  always_comb begin
    we_s         = 1'b0;
    waddr_s      = {ADDR_W{1'b0}};
    wdata_s      = {COLS{1'b0}};
    fsm_raddr_s  = rp_r;
    lock_ready_s = 1'b0;
    busy_s       = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        lock_ready_s = 1'b1;
        fsm_raddr_s  = bus.lock_row;
        // A same-cycle wipe or clear drops the lock
        if (bus.lock_valid && !bus.board_wipe && !bus.clear_start &&
            (bus.lock_row <= LAST_ROW)) begin
          we_s    = 1'b1;
          waddr_s = bus.lock_row;
          wdata_s = fsm_rdata_s | bus.lock_mask;
        end else begin
          we_s = 1'b0;
        end
      end
      SCAN: begin
        busy_s = 1'b1;
        // Non-full rows slide down to the write pointer; full rows are skipped
        if (!row_full_s) begin
          we_s    = 1'b1;
          waddr_s = wp_r;
          wdata_s = fsm_rdata_s;
        end else begin
          we_s = 1'b0;
        end
      end
      FILL, WIPE: begin
        busy_s  = 1'b1;
        we_s    = 1'b1;
        waddr_s = wp_r;
        wdata_s = {COLS{1'b0}};
      end
      DONE:    done_s = 1'b1;
      default: done_s = 1'b0;
    endcase
  end

  // Read/write pointers and full-row counter
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      rp_r    <= LAST_ROW;
      wp_r    <= LAST_ROW;
      count_r <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          rp_r    <= LAST_ROW;
          wp_r    <= LAST_ROW;
          count_r <= 3'd0;
        end
        SCAN: begin
          rp_r    <= rp_r - 5'd1;
          count_r <= count_next_s;
          if (!row_full_s) begin
            wp_r <= wp_r - 5'd1;
          end
        end
        FILL, WIPE: wp_r <= wp_r - 5'd1;
        default:    rp_r <= rp_r;
      endcase
    end
  end

  // Result count: latched as the operation completes, zero after a wipe
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      lines_r <= 3'd0;
    end else if ((state_r != DONE) && (next_state_s == DONE)) begin
      lines_r <= (state_r == WIPE) ? 3'd0 : count_next_s;
    end
  end

  // Registered renderer data, one cycle after the address
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= {COLS{1'b0}};
    end else begin
      rd_data_r <= ren_rdata_s;
    end
  end

endmodule

// File: tb/tb_game_area_store.sv
// Directed, table-driven bench for game_area_store.
module tb_game_area_store;

  logic clk;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  game_area_store_if #(.COLS(12)) bus ();

  game_area_store dut (
    .vga_clk (clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  row;
    logic [11:0] mask;
    logic [4:0]  raddr;
    logic [11:0] exp;
  } lock_vec_t;

  lock_vec_t   vecs [6];
  logic [11:0] exp_board [20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < 20; i++) begin
      bus.rd_addr = 5'(i);
      tick();
      check($sformatf("%s_row%0d", name, i), 32'(bus.rd_data), 32'(exp_board[i]));
    end
  endtask

  task automatic do_lock(input logic [4:0] row, input logic [11:0] mask);
    bus.lock_valid = 1'b1;
    bus.lock_row   = row;
    bus.lock_mask  = mask;
    tick();
    bus.lock_valid = 1'b0;
  endtask

  // Pulse clear/wipe and count cycles until done (bounded)
  task automatic run_op(input string name, input logic do_clear, input logic do_wipe,
                        output int cyc);
    bus.clear_start = do_clear;
    bus.board_wipe  = do_wipe;
    tick();
    cyc = 1;
    bus.clear_start = 1'b0;
    bus.board_wipe  = 1'b0;
    check({name, "_busy_rise"}, 32'(bus.busy), 32'd1);
    check({name, "_lock_ready_low"}, 32'(bus.lock_ready), 32'd0);
    while (!bus.done && cyc < 60) begin
      tick();
      cyc++;
    end
    check({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    tick();
    check({name, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int cyc;
    int done_seen;

    bus.rd_addr     = 5'd0;
    bus.lock_valid  = 1'b0;
    bus.lock_row    = 5'd0;
    bus.lock_mask   = 12'h000;
    bus.clear_start = 1'b0;
    bus.board_wipe  = 1'b0;

    vecs[0] = '{row: 5'd19, mask: 12'h0F0, raddr: 5'd19, exp: 12'h0F0};
    vecs[1] = '{row: 5'd19, mask: 12'h00F, raddr: 5'd19, exp: 12'h0FF};
    vecs[2] = '{row: 5'd22, mask: 12'hFFF, raddr: 5'd19, exp: 12'h0FF};
    vecs[3] = '{row: 5'd0,  mask: 12'h800, raddr: 5'd0,  exp: 12'h800};
    vecs[4] = '{row: 5'd0,  mask: 12'h001, raddr: 5'd0,  exp: 12'h801};
    vecs[5] = '{row: 5'd31, mask: 12'hFFF, raddr: 5'd22, exp: 12'h000};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_lock_ready", 32'(bus.lock_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_lines", 32'(bus.lines_cleared), 32'd0);
    for (int i = 0; i < 20; i++) exp_board[i] = 12'h000;
    sweep("rst");
    bus.rd_addr = 5'd25;
    tick();
    check("rst_addr25", 32'(bus.rd_data), 32'd0);

    // Lock vectors
    for (int v = 0; v < 6; v++) begin
      do_lock(vecs[v].row, vecs[v].mask);
      bus.rd_addr = vecs[v].raddr;
      tick();
      check($sformatf("lock_vec%0d", v), 32'(bus.rd_data), 32'(vecs[v].exp));
    end
    for (int i = 0; i < 20; i++) exp_board[i] = 12'h000;
    exp_board[0]  = 12'h801;
    exp_board[19] = 12'h0FF;
    sweep("lock_board");

    // Wipe and clear together: wipe wins
    run_op("wipeclr", 1'b1, 1'b1, cyc);
    check("wipeclr_cycles", 32'(cyc), 32'd21);
    check("wipeclr_lines", 32'(bus.lines_cleared), 32'd0);
    for (int i = 0; i < 20; i++) exp_board[i] = 12'h000;
    sweep("wipeclr");

    // Two full rows, back-to-back locks
    do_lock(5'd19, 12'hFFF);
    do_lock(5'd18, 12'h001);
    do_lock(5'd17, 12'hFFF);
    do_lock(5'd16, 12'h800);
    run_op("clr2", 1'b1, 1'b0, cyc);
    check("clr2_cycles", 32'(cyc), 32'd23);
    check("clr2_lines", 32'(bus.lines_cleared), 32'd2);
    for (int i = 0; i < 20; i++) exp_board[i] = 12'h000;
    exp_board[19] = 12'h001;
    exp_board[18] = 12'h800;
    sweep("clr2");

    // No full rows: board unchanged
    run_op("clr0", 1'b1, 1'b0, cyc);
    check("clr0_cycles", 32'(cyc), 32'd21);
    check("clr0_lines", 32'(bus.lines_cleared), 32'd0);
    sweep("clr0");

    // Reset during SCAN
    do_lock(5'd10, 12'hFFF);
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    check("rstscan_busy_pre", 32'(bus.busy), 32'd1);
    repeat (4) tick();
    rst = 1'b1;
    #2;
    check("rstscan_busy", 32'(bus.busy), 32'd0);
    check("rstscan_ready", 32'(bus.lock_ready), 32'd1);
    #2;
    rst = 1'b0;
    do_lock(5'd5, 12'h003);
    bus.rd_addr = 5'd5;
    tick();
    check("rstscan_lock", 32'(bus.rd_data), 32'h003);
    done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.done) done_seen++;
    end
    check("rstscan_no_done", 32'(done_seen), 32'd0);
    for (int i = 0; i < 20; i++) exp_board[i] = 12'h000;
    exp_board[5] = 12'h003;
    sweep("rstscan");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
